// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels between a command source and alu_cmd_sequencer.
// master = command source / response consumer, slave = sequencer.
interface alu_cmd_sequencer_if #(
  parameter int BITS = 4
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [1:0]      cmd_dst;
  logic [1:0]      cmd_src_a;
  logic [1:0]      cmd_src_b;
  logic            cmd_imm_en;
  logic [BITS-1:0] cmd_imm;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_data;
  logic [1:0]      rsp_dst;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_dst
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_dst
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives a combinational ALU from a 4-entry register file; accept -> EXEC -> RESP, one command per 3 cycles.
// Response is held in RESP until rsp_ready; cmd_ready is low for the whole operation and any stall.
module alu_cmd_sequencer #(
  parameter int BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   bus,
  output logic [BITS-1:0]      alu_a,
  output logic [BITS-1:0]      alu_b,
  output logic [1:0]           alu_op,
  input  logic [BITS-1:0]      alu_out,
  input  logic [1:0]           dbg_addr,
  output logic [BITS-1:0]      dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] rf_q [4];
  logic [BITS-1:0] rf_d [4];
  logic [BITS-1:0] alu_a_q, alu_a_d;
  logic [BITS-1:0] alu_b_q, alu_b_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic [1:0]      dst_q, dst_d;
  logic [BITS-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_dst_q, rsp_dst_d;

  always_comb begin
    state_d    = state_q;
    rf_d       = rf_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    dst_d      = dst_q;
    rsp_data_d = rsp_data_q;
    rsp_dst_d  = rsp_dst_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_op_d = bus.cmd_op;
          alu_a_d  = rf_q[bus.cmd_src_a];
          alu_b_d  = bus.cmd_imm_en ? bus.cmd_imm : rf_q[bus.cmd_src_b];
          dst_d    = bus.cmd_dst;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // ALU inputs have been stable for the whole cycle; capture its result here.
        rf_d[dst_q] = alu_out;
        rsp_data_d  = alu_out;
        rsp_dst_d   = dst_q;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      dst_q      <= '0;
      rsp_data_q <= '0;
      rsp_dst_q  <= '0;
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      dst_q      <= dst_d;
      rsp_data_q <= rsp_data_d;
      rsp_dst_q  <= rsp_dst_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_dst   = rsp_dst_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign dbg_data      = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed commands with hand-computed results,
// expected responses queued at issue and checked by a separate monitor on each handshake.
module tb_alu_cmd_sequencer;
  localparam int BITS = 4;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11;

  typedef struct packed {
    logic [1:0]      dst;
    logic [BITS-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [BITS-1:0] alu_a, alu_b, alu_out, dbg_data;
  logic [1:0]      alu_op, dbg_addr;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  alu_cmd_sequencer_if #(.BITS(BITS)) bus_if ();

  alu_cmd_sequencer #(.BITS(BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // The attached 4-function ALU.
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      default: alu_out = alu_a | alu_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rf(input logic [1:0] idx, input logic [BITS-1:0] exp);
    dbg_addr = idx;
    #1;
    check($sformatf("dbg_rf%0d", idx), 32'(dbg_data), 32'(exp));
  endtask

  // Monitor: one comparison per response handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.rsp_valid && bus_if.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data 0x%0h dst %0d, expected no response", bus_if.rsp_data, bus_if.rsp_dst);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_data", 32'(bus_if.rsp_data), 32'(mon_e.data));
          check("rsp_dst",  32'(bus_if.rsp_dst),  32'(mon_e.dst));
        end
      end
    end
  end

  task automatic run_cmd(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic ie, input logic [BITS-1:0] imm,
                         input logic [BITS-1:0] ea, input logic [BITS-1:0] eb,
                         input logic [BITS-1:0] er, input int stall);
    exp_t e;
    @(posedge clk); #1;
    bus_if.cmd_op     = op;
    bus_if.cmd_dst    = dst;
    bus_if.cmd_src_a  = sa;
    bus_if.cmd_src_b  = sb;
    bus_if.cmd_imm_en = ie;
    bus_if.cmd_imm    = imm;
    bus_if.cmd_valid  = 1'b1;
    dbg_addr          = dst;
    e.dst  = dst;
    e.data = er;
    exp_q.push_back(e);
    @(negedge clk);
    check("cmd_ready_idle", 32'(bus_if.cmd_ready), 1);
    @(posedge clk); #1;                       // accept edge N
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);                           // EXEC
    check("exec_alu_a",     32'(alu_a), 32'(ea));
    check("exec_alu_b",     32'(alu_b), 32'(eb));
    check("exec_alu_op",    32'(alu_op), 32'(op));
    check("exec_rsp_valid", 32'(bus_if.rsp_valid), 0);
    check("exec_cmd_ready", 32'(bus_if.cmd_ready), 0);
    @(posedge clk); #1;                       // edge N+1
    if (stall == 0) bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid_n1", 32'(bus_if.rsp_valid), 1);
    check("dbg_writeback", 32'(dbg_data), 32'(er));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        bus_if.cmd_op     = OP_ADD;
        bus_if.cmd_dst    = 2'd0;
        bus_if.cmd_src_a  = 2'd0;
        bus_if.cmd_imm_en = 1'b1;
        bus_if.cmd_imm    = 4'hF;
        bus_if.cmd_valid  = 1'b1;
      end else begin
        bus_if.cmd_valid  = 1'b0;
      end
      @(negedge clk);
      check("stall_rsp_valid", 32'(bus_if.rsp_valid), 1);
      check("stall_cmd_ready", 32'(bus_if.cmd_ready), 0);
      check("stall_rsp_data",  32'(bus_if.rsp_data), 32'(er));
      check("stall_rsp_dst",   32'(bus_if.rsp_dst), 32'(dst));
      check("stall_alu_a",     32'(alu_a), 32'(ea));
      check("stall_alu_b",     32'(alu_b), 32'(eb));
    end
    if (stall > 0) begin
      @(posedge clk); #1;
      bus_if.cmd_valid = 1'b0;
      bus_if.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;                       // handshake edge
    bus_if.rsp_ready = 1'b0;
    @(negedge clk);
    check("post_hs_cmd_ready", 32'(bus_if.cmd_ready), 1);
    check("post_hs_rsp_valid", 32'(bus_if.rsp_valid), 0);
  endtask

  task automatic reset_mid(input logic [1:0] dst, input logic [BITS-1:0] imm, input int extra);
    @(posedge clk); #1;
    bus_if.cmd_op     = OP_ADD;
    bus_if.cmd_dst    = dst;
    bus_if.cmd_src_a  = 2'd0;
    bus_if.cmd_imm_en = 1'b1;
    bus_if.cmd_imm    = imm;
    bus_if.cmd_valid  = 1'b1;
    dbg_addr          = dst;
    @(posedge clk); #1;                       // now in EXEC
    bus_if.cmd_valid  = 1'b0;
    for (int i = 0; i < extra; i++) begin
      @(posedge clk); #1;
    end
    if (extra > 0) begin
      check("resp_before_reset", 32'(bus_if.rsp_valid), 1);
      check("wb_before_reset",   32'(dbg_data), 32'(imm));
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 0);
    check("rst_cmd_ready", 32'(bus_if.cmd_ready), 1);
    check("rst_alu_a",     32'(alu_a), 0);
    check("rst_alu_b",     32'(alu_b), 0);
    check("rst_dbg_dst",   32'(dbg_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_rsp_after_reset", 32'(bus_if.rsp_valid), 0);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_op     = 2'd0;
    bus_if.cmd_dst    = 2'd0;
    bus_if.cmd_src_a  = 2'd0;
    bus_if.cmd_src_b  = 2'd0;
    bus_if.cmd_imm_en = 1'b0;
    bus_if.cmd_imm    = '0;
    bus_if.rsp_ready  = 1'b0;
    dbg_addr          = 2'd0;
    rst_n             = 1'b0;
    #7 rst_n = 1'b1;
    @(negedge clk);
    check("reset_rsp_valid", 32'(bus_if.rsp_valid), 0);
    check("reset_cmd_ready", 32'(bus_if.cmd_ready), 1);
    check("reset_alu_a",     32'(alu_a), 0);
    check("reset_alu_b",     32'(alu_b), 0);
    check("reset_alu_op",    32'(alu_op), 0);
    check("reset_rsp_data",  32'(bus_if.rsp_data), 0);
    check("reset_rsp_dst",   32'(bus_if.rsp_dst), 0);
    for (int i = 0; i < 4; i++) check_rf(2'(i), 4'h0);

    //        op      dst   sa    sb    ie    imm    ea     eb     er     stall
    run_cmd(OP_ADD, 2'd1, 2'd0, 2'd2, 1'b1, 4'h5, 4'h0, 4'h5, 4'h5, 0);
    run_cmd(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b1, 4'h9, 4'h0, 4'h9, 4'h9, 0);
    check_rf(2'd1, 4'h5);
    check_rf(2'd2, 4'h9);
    run_cmd(OP_SUB, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'h5, 4'h9, 4'hC, 0);
    run_cmd(OP_ADD, 2'd0, 2'd2, 2'd2, 1'b0, 4'h0, 4'h9, 4'h9, 4'h2, 0);
    run_cmd(OP_AND, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'h5, 4'h9, 4'h1, 0);
    run_cmd(OP_OR,  2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'h5, 4'h9, 4'hD, 5);
    check_rf(2'd0, 4'h2);
    check_rf(2'd1, 4'h5);
    check_rf(2'd2, 4'h9);
    check_rf(2'd3, 4'hD);

    reset_mid(2'd1, 4'h7, 0);
    for (int i = 0; i < 4; i++) check_rf(2'(i), 4'h0);
    reset_mid(2'd2, 4'h3, 1);
    check_rf(2'd2, 4'h0);

    run_cmd(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 4'h6, 4'h0, 4'h6, 4'h6, 0);
    check_rf(2'd3, 4'h6);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
